wasm_prog_loader: RTL and testbench
===================================

// Module: wasm_prog_loader
// PURPOSE
//  Upstream stage of WASM_TOP: receives a length-prefixed WASM program as a byte stream,
//  writes it into the instruction BRAM, then releases the core from reset and supervises
//  the run. Counts cycles from core release to o_instr_finish and reports completion status.
//  Replaces file preloading, so programs can be loaded and rerun on hardware.
// PARAMETERS
//  ADDR_W   10   instruction BRAM address width (depth = 2**ADDR_W bytes)
//  CNT_W    32   cycle counter width
//  TIMEOUT  500  max RUN cycles before abort (must be >= 1)
//  RST_HOLD 2    cycles o_core_rst_n is held low after the load completes (must be >= 1)
// PORTS
//  i_clk           in   1       clock
//  i_rst           in   1       synchronous, active-high reset
//  i_start         in   1       1-cycle pulse; starts a session (honoured only in IDLE/DONE)
//  i_byte_valid    in   1       stream byte valid
//  o_byte_ready    out  1       stream byte ready
//  i_byte_data     in   8       stream byte
//  o_bram_we       out  1       instruction BRAM write enable
//  o_bram_addr     out  ADDR_W  instruction BRAM byte address
//  o_bram_wdata    out  8       instruction BRAM write data
//  o_core_rst_n    out  1       drives WASM_TOP i_rst_n
//  i_instr_finish  in   1       from WASM_TOP o_instr_finish
//  i_instr_error   in   1       from WASM_TOP o_INSTR_ERROR
//  i_stack_full    in   1       from WASM_TOP o_stack_full
//  o_busy          out  1       high from i_start acceptance until DONE
//  o_done          out  1       level; high in DONE, cleared by the next accepted i_start
//  o_status        out  3       0 OK, 1 INSTR_ERR, 2 STACK_FULL, 3 TIMEOUT, 4 BAD_LEN
//  o_cycle_cnt     out  CNT_W   RUN cycles counted; frozen in DONE
// BEHAVIOUR
//  All outputs are registered. Reset value of every output is 0, including o_core_rst_n
//  (core held in reset). A reset mid-session aborts immediately: state IDLE, no further writes.
//  Byte handshake: a byte is accepted on a cycle with i_byte_valid & o_byte_ready.
//  o_byte_ready = 1 only in HDR_LO, HDR_HI and LOAD.
//  FSM:
//   IDLE   -> HDR_LO on i_start; clear o_done, o_status, o_cycle_cnt; o_busy<=1.
//   HDR_LO -> HDR_HI on accept; LEN[7:0] <= byte.
//   HDR_HI -> on accept, LEN[15:8] <= byte; then:
//            - LEN==0 or LEN > 2**ADDR_W: go to DONE, status BAD_LEN; no BRAM write occurs.
//            - otherwise: go to LOAD with idx=0.
//   LOAD   -> on each accept, on the next cycle drive o_bram_we=1, o_bram_addr=idx,
//            o_bram_wdata=byte; idx++. On accepting byte LEN-1, go to CORE_RST.
//            o_bram_we is never asserted outside these write cycles.
//   CORE_RST: o_core_rst_n=0 for RST_HOLD cycles (covers the final write); then RUN.
//   RUN    : o_core_rst_n=1. o_cycle_cnt=0 on the first RUN cycle and increments once per cycle.
//            Exit checks each cycle, priority: error > stack_full > finish > timeout.
//            The completion condition that ends RUN is evaluated on the same cycle; on
//            leaving RUN the count is frozen at its value on that cycle.
//            Timeout fires when the count equals TIMEOUT-1 with no other condition present.
//            The counter saturates at all-ones and never wraps.
//   DONE   : o_done=1, o_busy=0, o_status holds. o_core_rst_n stays 1 so core state can be
//            inspected. i_start -> HDR_LO, o_core_rst_n<=0, o_done, o_status and
//            o_cycle_cnt cleared.
//  o_core_rst_n is 0 in every state except RUN and DONE.
//  Ignored inputs: i_start outside IDLE/DONE; i_instr_* and i_stack_full outside RUN;
//  bytes offered while o_byte_ready=0 (not consumed).
//  LEN = 2**ADDR_W is legal: the last write address is 2**ADDR_W-1, and idx does not wrap
//  within a load.
// TESTING
//  1 Start; stream 03 00 41 2A 0B; core model asserts finish 7 cycles after release ->
//    BRAM addr 0..2 = 41,2A,0B; status 0; o_cycle_cnt=6; o_done=1.
//  2 Header 00 00 -> DONE within 1 cycle of HDR_HI accept; status 4; o_bram_we never high.
//  3 Header length 2**ADDR_W+1 -> status 4. Header length exactly 2**ADDR_W -> full load;
//    last write at addr 2**ADDR_W-1.
//  4 Core model never finishes -> status 3, o_cycle_cnt=TIMEOUT-1.
//  5 i_instr_error and i_instr_finish high on the same RUN cycle -> status 1.
//  6 Source toggles valid randomly; core stalls for 10 cycles -> byte order and addresses intact.
//  7 Assert i_rst mid-LOAD, then start a new session -> all outputs 0 after reset, and the
//    second load completes with status 0.

Source files
------------

// File: rtl/wasm_prog_loader.sv
// Loads a length-prefixed WASM program from a byte stream into instruction BRAM.
// It then releases the core from reset, times the run and reports why it ended.
module wasm_prog_loader #(
    parameter int ADDR_W   = 10,
    parameter int CNT_W    = 32,
    parameter int TIMEOUT  = 500,
    parameter int RST_HOLD = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    input  logic [7:0]        i_byte_data,
    output logic              o_bram_we,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [7:0]        o_bram_wdata,
    output logic              o_core_rst_n,
    input  logic              i_instr_finish,
    input  logic              i_instr_error,
    input  logic              i_stack_full,
    output logic              o_busy,
    output logic              o_done,
    output logic [2:0]        o_status,
    output logic [CNT_W-1:0]  o_cycle_cnt,
    output logic [2:0]        dbg_state
);
    localparam int LEN_W  = 17;
    localparam int HOLD_W = $clog2(RST_HOLD + 1);

    localparam logic [2:0] ST_OK         = 3'd0;
    localparam logic [2:0] ST_INSTR_ERR  = 3'd1;
    localparam logic [2:0] ST_STACK_FULL = 3'd2;
    localparam logic [2:0] ST_TIMEOUT    = 3'd3;
    localparam logic [2:0] ST_BAD_LEN    = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_LO, S_HDR_HI, S_LOAD, S_CORE_RST, S_RUN, S_DONE
    } state_t;

    state_t            state, state_next;
    logic [15:0]       len;
    logic [ADDR_W-1:0] idx;
    logic [HOLD_W-1:0] hold;
    logic [LEN_W-1:0]  hdr_len;
    logic              accept, bad_len, last_byte, hold_done, run_exit;
    logic [2:0]        exit_status;

    assign dbg_state = state;

    // Byte stream: a byte transfers on each rising edge where i_byte_valid and
    // o_byte_ready are both high; ready depends only on state, never on valid.
    always_comb begin
        state_next  = state;
        accept      = o_byte_ready & i_byte_valid;
        hdr_len     = {1'b0, i_byte_data, len[7:0]};
        bad_len     = (hdr_len == '0) || (hdr_len > (LEN_W'(1) << ADDR_W));
        last_byte   = ({{(LEN_W-ADDR_W){1'b0}}, idx} == ({1'b0, len} - LEN_W'(1)));
        hold_done   = (hold == HOLD_W'(RST_HOLD - 1));
        run_exit    = 1'b0;
        exit_status = ST_OK;
        if (i_instr_error) begin
            run_exit    = 1'b1;
            exit_status = ST_INSTR_ERR;
        end else if (i_stack_full) begin
            run_exit    = 1'b1;
            exit_status = ST_STACK_FULL;
        end else if (i_instr_finish) begin
            run_exit    = 1'b1;
            exit_status = ST_OK;
        end else if (o_cycle_cnt == CNT_W'(TIMEOUT - 1)) begin
            run_exit    = 1'b1;
            exit_status = ST_TIMEOUT;
        end

        case (state)
            S_IDLE, S_DONE: if (i_start) state_next = S_HDR_LO;
            S_HDR_LO:       if (accept) state_next = S_HDR_HI;
            S_HDR_HI:       if (accept) state_next = bad_len ? S_DONE : S_LOAD;
            S_LOAD:         if (accept && last_byte) state_next = S_CORE_RST;
            S_CORE_RST:     if (hold_done) state_next = S_RUN;
            S_RUN:          if (run_exit) state_next = S_DONE;
            default:        state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            len          <= '0;
            idx          <= '0;
            hold         <= '0;
            o_byte_ready <= 1'b0;
            o_bram_we    <= 1'b0;
            o_bram_addr  <= '0;
            o_bram_wdata <= '0;
            o_core_rst_n <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_status     <= '0;
            o_cycle_cnt  <= '0;
        end else begin
            state        <= state_next;
            o_byte_ready <= (state_next inside {S_HDR_LO, S_HDR_HI, S_LOAD});
            o_busy       <= (state_next inside {S_HDR_LO, S_HDR_HI, S_LOAD, S_CORE_RST, S_RUN});
            o_done       <= (state_next == S_DONE);
            // DONE keeps whatever reset level it inherited: released after a run, held after BAD_LEN.
            o_core_rst_n <= (state_next == S_RUN) || ((state_next == S_DONE) && o_core_rst_n);
            o_bram_we    <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        o_status    <= ST_OK;
                        o_cycle_cnt <= '0;
                    end
                end
                S_HDR_LO: if (accept) len[7:0] <= i_byte_data;
                S_HDR_HI: begin
                    if (accept) begin
                        len[15:8] <= i_byte_data;
                        idx       <= '0;
                        if (bad_len) o_status <= ST_BAD_LEN;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        o_bram_we    <= 1'b1;
                        o_bram_addr  <= idx;
                        o_bram_wdata <= i_byte_data;
                        idx          <= idx + 1'b1;
                        hold         <= '0;
                    end
                end
                S_CORE_RST: begin
                    hold        <= hold + 1'b1;
                    o_cycle_cnt <= '0;
                end
                S_RUN: begin
                    if (run_exit) o_status <= exit_status;
                    else if (o_cycle_cnt != '1) o_cycle_cnt <= o_cycle_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wasm_prog_loader.sv
// Directed bench for wasm_prog_loader: BRAM writes and run results are queued as
// expectations when stimulus is issued and checked by an independent monitor.
module tb_wasm_prog_loader;
    localparam int ADDR_W   = 4;
    localparam int CNT_W    = 32;
    localparam int TIMEOUT  = 20;
    localparam int RST_HOLD = 2;

    logic              clk;
    logic              rst, start, byte_valid, byte_ready;
    logic [7:0]        byte_data;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_wdata;
    logic              core_rst_n, instr_finish, instr_error, stack_full;
    logic              busy, done;
    logic [2:0]        status;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [2:0]        dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [ADDR_W+7:0] wr_exp_q[$];
    logic [CNT_W+2:0]  res_exp_q[$];
    logic [7:0]        prog[0:31];
    logic              done_prev;

    wasm_prog_loader #(
        .ADDR_W(ADDR_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .RST_HOLD(RST_HOLD)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .i_byte_valid(byte_valid), .o_byte_ready(byte_ready), .i_byte_data(byte_data),
        .o_bram_we(bram_we), .o_bram_addr(bram_addr), .o_bram_wdata(bram_wdata),
        .o_core_rst_n(core_rst_n), .i_instr_finish(instr_finish),
        .i_instr_error(instr_error), .i_stack_full(stack_full),
        .o_busy(busy), .o_done(done), .o_status(status), .o_cycle_cnt(cycle_cnt),
        .dbg_state(dbg_state)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        tests_failed++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string msg);
        tests_run++;
        tests_failed++;
        $display("FAIL %s", msg);
    endtask

    // Monitor: pops expectations whenever the DUT writes BRAM or enters DONE.
    initial done_prev = 1'b0;
    always @(negedge clk) begin
        logic [ADDR_W+7:0] w;
        logic [CNT_W+2:0]  r;
        if (bram_we) begin
            if (wr_exp_q.size() == 0) begin
                fail_now($sformatf("bram_write: unexpected write addr 0x%0h data 0x%0h",
                                   bram_addr, bram_wdata));
            end else begin
                w = wr_exp_q.pop_front();
                check("bram_addr", 64'(bram_addr), 64'(w[ADDR_W+7:8]));
                check("bram_wdata", 64'(bram_wdata), 64'(w[7:0]));
            end
        end
        if (done && !done_prev) begin
            if (res_exp_q.size() == 0) begin
                fail_now($sformatf("done: unexpected completion status %0d", status));
            end else begin
                r = res_exp_q.pop_front();
                check("status", 64'(status), 64'(r[CNT_W+2:CNT_W]));
                check("cycle_cnt", 64'(cycle_cnt), 64'(r[CNT_W-1:0]));
                check("busy_in_done", 64'(busy), 64'(0));
            end
        end
        done_prev = done;
    end

    // Driver tasks: all inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit accepted;
        int guard;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        accepted   = 1'b0;
        guard      = 0;
        while (!accepted && guard < 200) begin
            @(negedge clk);
            accepted = byte_ready;
            tick();
            guard++;
        end
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        if (!accepted) fail_now("byte_accept: ready never asserted");
    endtask

    task automatic load(input int hdr_len, input int n, input bit rnd);
        send_byte(hdr_len[7:0], rnd ? int'($urandom_range(0, 3)) : 0);
        send_byte(hdr_len[15:8], rnd ? int'($urandom_range(0, 3)) : 0);
        for (int i = 0; i < n; i++) begin
            wr_exp_q.push_back({ADDR_W'(i), prog[i]});
            send_byte(prog[i], rnd ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    // Core model: mode 0 finish, 1 error+finish, 2 stack_full+finish, 3 never ends.
    // The chosen signals are high during the RUN cycle whose count equals at_cnt.
    task automatic run_core(input int mode, input int at_cnt);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!core_rst_n && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!core_rst_n) begin
            fail_now("core_release: o_core_rst_n never went high");
            return;
        end
        if (mode == 3) return;
        repeat (at_cnt) tick();
        instr_finish = 1'b1;
        instr_error  = (mode == 1);
        stack_full   = (mode == 2);
        tick();
        instr_finish = 1'b0;
        instr_error  = 1'b0;
        stack_full   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int g;
        g = 0;
        while (!done && g < budget) begin
            @(negedge clk);
            g++;
        end
        if (!done) fail_now("wait_done: o_done never asserted");
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  64'(byte_ready), 64'(0));
        check({tag, "_we"},     64'(bram_we), 64'(0));
        check({tag, "_addr"},   64'({bram_addr, bram_wdata}), 64'(0));
        check({tag, "_rst_n"},  64'(core_rst_n), 64'(0));
        check({tag, "_flags"},  64'({busy, done, status}), 64'(0));
        check({tag, "_cnt"},    64'(cycle_cnt), 64'(0));
        check({tag, "_state"},  64'(dbg_state), 64'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        instr_finish = 1'b0; instr_error = 1'b0; stack_full = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // 1: three-byte program, finish on the 7th RUN cycle
        res_exp_q.push_back({3'd0, CNT_W'(6)});
        pulse_start();
        check("busy_after_start", 64'(busy), 64'(1));
        prog[0] = 8'h41; prog[1] = 8'h2A; prog[2] = 8'h0B;
        load(3, 3, 1'b0);
        run_core(0, 6);
        wait_done(200);
        check("rst_n_in_done", 64'(core_rst_n), 64'(1));
        check("t1_writes_drained", 64'(wr_exp_q.size()), 64'(0));

        // 2: zero length header
        res_exp_q.push_back({3'd4, CNT_W'(0)});
        pulse_start();
        check("rst_n_after_restart", 64'(core_rst_n), 64'(0));
        check("done_cleared", 64'(done), 64'(0));
        load(0, 0, 1'b0);
        check("badlen0_done_fast", 64'(done), 64'(1));
        repeat (3) tick();

        // 3a: one byte too long
        res_exp_q.push_back({3'd4, CNT_W'(0)});
        pulse_start();
        load((1 << ADDR_W) + 1, 0, 1'b0);
        wait_done(10);

        // 3b: exactly full BRAM, finish on first RUN cycle
        for (int i = 0; i < (1 << ADDR_W); i++) prog[i] = 8'(i * 7 + 3);
        res_exp_q.push_back({3'd0, CNT_W'(0)});
        pulse_start();
        load(1 << ADDR_W, 1 << ADDR_W, 1'b0);
        run_core(0, 0);
        wait_done(200);

        // 4: core never finishes
        prog[0] = 8'hA5; prog[1] = 8'h5A;
        res_exp_q.push_back({3'd3, CNT_W'(TIMEOUT - 1)});
        pulse_start();
        load(2, 2, 1'b0);
        run_core(3, 0);
        wait_done(200);

        // 5: error and finish together
        prog[0] = 8'hC3;
        res_exp_q.push_back({3'd1, CNT_W'(3)});
        pulse_start();
        load(1, 1, 1'b0);
        run_core(1, 3);
        wait_done(200);

        // stack_full beats finish
        res_exp_q.push_back({3'd2, CNT_W'(2)});
        pulse_start();
        load(1, 1, 1'b0);
        run_core(2, 2);
        wait_done(200);

        // 6: bursty source, core stalls 10 cycles
        prog[0] = 8'h10; prog[1] = 8'h21; prog[2] = 8'h32;
        prog[3] = 8'h43; prog[4] = 8'h54; prog[5] = 8'h65;
        res_exp_q.push_back({3'd0, CNT_W'(10)});
        pulse_start();
        load(6, 6, 1'b1);
        run_core(0, 10);
        wait_done(200);

        // 7: reset in the middle of a load, then a clean session
        prog[0] = 8'h77; prog[1] = 8'h88;
        pulse_start();
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 2; i++) begin
            wr_exp_q.push_back({ADDR_W'(i), prog[i]});
            send_byte(prog[i], 0);
        end
        rst = 1'b1;
        byte_valid = 1'b1;
        byte_data  = 8'hEE;
        tick();
        tick();
        @(negedge clk);
        check_all_zero("midload_reset");
        check("midload_writes_drained", 64'(wr_exp_q.size()), 64'(0));
        tick();
        rst = 1'b0;
        byte_valid = 1'b0;
        repeat (3) tick();
        prog[0] = 8'h01; prog[1] = 8'h02; prog[2] = 8'h03;
        res_exp_q.push_back({3'd0, CNT_W'(4)});
        pulse_start();
        load(3, 3, 1'b1);
        run_core(0, 4);
        wait_done(200);

        repeat (5) tick();
        check("final_writes_drained", 64'(wr_exp_q.size()), 64'(0));
        check("final_results_drained", 64'(res_exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
